// File: rtl/timer_pkg.sv
// Shared types and helpers for the timer controller.
package timer_pkg;

  // FSM encoding; 2'd3 is never produced.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } timer_state_e;

  // True for the states in which the timer holds a live period.
  function automatic logic is_active(input timer_state_e st);
    return (st == RUN) || (st == PAUSED);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into count ticks: one tick every Prescale enabled cycles.
module tick_prescaler #(
  parameter int Prescale = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable,
  input  logic clear,
  output logic tick_o
);

  // At least one bit so Prescale=1 still has a (constant-zero) counter.
  localparam int PW = (Prescale > 1) ? $clog2(Prescale) : 1;
  localparam logic [PW-1:0] PLast = PW'(Prescale - 1);

  logic [PW-1:0] cnt_q;

  // Tick on the enabled cycle in which the divider sits at its last value.
  assign tick_o = enable && (cnt_q == PLast);

  // Divider counter: clear has priority, otherwise advance and wrap when enabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      if (cnt_q == PLast) cnt_q <= '0;
      else                cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Start/stop/pause timer with one-shot or periodic expiry and an event
// handshake towards a downstream consumer.
//
// Event handshake: evt_valid_o rises the cycle after an expiry and stays high
// until a cycle in which evt_ready_i is also high; that cycle transfers the
// event. evt_valid_o never drops without such a transfer (except on reset).
// An expiry in a transfer cycle starts a new event; an expiry while an event
// is stalled is lost and latches missed_o.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int Limit    = 16,
  parameter int Prescale = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     pause_i,
  input  logic                     periodic_i,
  input  logic                     evt_ready_i,
  input  logic                     missed_clr_i,
  output logic [1:0]               state_o,
  output logic [$clog2(Limit)-1:0] count_o,
  output logic                     evt_valid_o,
  output logic                     missed_o
);

  localparam int CW = $clog2(Limit);
  // Compared one bit wider so a power-of-two Limit still has a distinct last value.
  localparam logic [CW:0] CLast = (CW+1)'(Limit - 1);

  timer_state_e  state_q;
  logic [CW-1:0] count_q;
  logic          evt_valid_q;
  logic          missed_q;

  logic counting;
  logic presc_en;
  logic presc_clr;
  logic tick;
  logic expire;

  // A period advances in RUN, and also in PAUSED once pause drops, so the
  // released cycle already counts and a pause of N cycles delays by exactly N.
  assign counting  = is_active(state_q) && !pause_i;
  assign presc_clr = stop_i || start_i;
  assign presc_en  = counting && !presc_clr;
  // Commands never coincide with an expiry because presc_en excludes them.
  assign expire    = tick && ({1'b0, count_q} == CLast);

  tick_prescaler #(
    .Prescale (Prescale)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .enable (presc_en),
    .clear  (presc_clr),
    .tick_o (tick)
  );

  // FSM and tick count, commands in priority stop > start > pause > tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      count_q <= '0;
    end else if (stop_i) begin
      state_q <= IDLE;
      count_q <= '0;
    end else if (start_i) begin
      state_q <= RUN;
      count_q <= '0;
    end else if (state_q == RUN && pause_i) begin
      state_q <= PAUSED;
    end else if (counting) begin
      state_q <= RUN;
      if (expire) begin
        count_q <= '0;
        if (!periodic_i) state_q <= IDLE;
      end else if (tick) begin
        count_q <= count_q + 1'b1;
      end
    end else if (!is_active(state_q)) begin
      state_q <= IDLE;
    end
  end

  // Pending event flag: new expiry sets, a transfer clears.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evt_valid_q <= 1'b0;
    end else if (expire) begin
      evt_valid_q <= 1'b1;
    end else if (evt_valid_q && evt_ready_i) begin
      evt_valid_q <= 1'b0;
    end
  end

  // Sticky lost-event flag; a new loss wins over a clear in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      missed_q <= 1'b0;
    end else if (expire && evt_valid_q && !evt_ready_i) begin
      missed_q <= 1'b1;
    end else if (missed_clr_i) begin
      missed_q <= 1'b0;
    end
  end

  assign state_o     = state_q;
  assign count_o     = count_q;
  assign evt_valid_o = evt_valid_q;
  assign missed_o    = missed_q;

endmodule
